// File: rtl/fpro_bus_arbiter.sv
// Two-master round-robin arbiter for the FPro bus with bounded lock bursts,
// registered bus outputs and per-master registered read-data return.
module fpro_bus_arbiter #(
  parameter int ADDR_W    = 21,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int INIT_LAST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_video,
  input  logic              m0_wr,
  input  logic              m0_rd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_rd_valid,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_video,
  input  logic              m1_wr,
  input  logic              m1_rd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_rd_valid,
  output logic              fp_mmio_cs,
  output logic              fp_video_cs,
  output logic              fp_wr,
  output logic              fp_rd,
  output logic [ADDR_W-1:0] fp_addr,
  output logic [DATA_W-1:0] fp_wr_data,
  input  logic [DATA_W-1:0] fp_rd_data
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] MAX_B     = 8'(MAX_BURST);
  localparam logic       LAST_INIT = 1'(INIT_LAST);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       last, last_nxt;
  logic       gnt0, gnt1;
  logic       held0, held1;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= MAX_B) ? MAX_B : 8'(c + 8'd1);
  endfunction

  // Arbitration and next-state
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = IDLE;
    cnt_nxt   = 8'd0;
    last_nxt  = last;
    held0     = (state == OWN0) && m0_lock && (cnt < MAX_B);
    held1     = (state == OWN1) && m1_lock && (cnt < MAX_B);

    if (m0_req && m1_req) begin
      if (held0)      gnt0 = 1'b1;
      else if (held1) gnt1 = 1'b1;
      else if (last)  gnt0 = 1'b1;
      else            gnt1 = 1'b1;
    end else if (m0_req) begin
      gnt0 = !held1;
    end else if (m1_req) begin
      gnt1 = !held0;
    end

    if (gnt0) begin
      last_nxt = 1'b0;
      if (m0_lock) begin
        state_nxt = OWN0;
        cnt_nxt   = (state == OWN0) ? sat_inc(cnt) : 8'd1;
      end
    end else if (gnt1) begin
      last_nxt = 1'b1;
      if (m1_lock) begin
        state_nxt = OWN1;
        cnt_nxt   = (state == OWN1) ? sat_inc(cnt) : 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      last  <= LAST_INIT;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  assign m0_ack = gnt0 & ~reset;
  assign m1_ack = gnt1 & ~reset;

  // Stage p0: granted command mux and decode
  logic              issue_p0, video_p0, wr_p0, rd_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  always_comb begin
    issue_p0 = gnt0 | gnt1;
    video_p0 = gnt1 ? m1_video   : m0_video;
    addr_p0  = gnt1 ? m1_addr    : m0_addr;
    wdata_p0 = gnt1 ? m1_wr_data : m0_wr_data;
    wr_p0    = issue_p0 & (gnt1 ? m1_wr : m0_wr);
    // Write wins over read; the video path has no read side at all.
    rd_p0    = issue_p0 & ~wr_p0 & (gnt1 ? m1_rd : m0_rd);
  end

  // Stage p1: registered bus beat plus pending read bookkeeping
  logic rd_pend_p1, rd_sel_p1, rd_video_p1;

  always_ff @(posedge clk) begin
    if (reset || !issue_p0) begin
      fp_mmio_cs  <= 1'b0;
      fp_video_cs <= 1'b0;
      fp_wr       <= 1'b0;
      fp_rd       <= 1'b0;
      fp_addr     <= '0;
      fp_wr_data  <= '0;
    end else begin
      fp_mmio_cs  <= ~video_p0 & (wr_p0 | rd_p0);
      fp_video_cs <= video_p0 & wr_p0;
      fp_wr       <= wr_p0;
      fp_rd       <= rd_p0 & ~video_p0;
      fp_addr     <= addr_p0;
      fp_wr_data  <= wdata_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_p1  <= 1'b0;
      rd_sel_p1   <= 1'b0;
      rd_video_p1 <= 1'b0;
    end else begin
      rd_pend_p1  <= rd_p0;
      rd_sel_p1   <= gnt1;
      rd_video_p1 <= video_p0;
    end
  end

  // Stage p2: per-master read return
  logic [DATA_W-1:0] rdata_p1;
  assign rdata_p1 = rd_video_p1 ? '0 : fp_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rd_valid <= 1'b0;
      m1_rd_valid <= 1'b0;
      m0_rd_data  <= '0;
      m1_rd_data  <= '0;
    end else begin
      m0_rd_valid <= rd_pend_p1 & ~rd_sel_p1;
      m1_rd_valid <= rd_pend_p1 & rd_sel_p1;
      if (rd_pend_p1 && !rd_sel_p1) m0_rd_data <= rdata_p1;
      if (rd_pend_p1 && rd_sel_p1)  m1_rd_data <= rdata_p1;
    end
  end

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Directed and randomized bench for fpro_bus_arbiter against a behavioural
// arbitration/bus model evaluated on every falling edge.
module tb_fpro_bus_arbiter;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
  localparam int MAXB   = 4;
  localparam int ILAST  = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req = '0, lock = '0, video = '0, wr = '0, rd = '0;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] slave_word = '0;

  logic m0_ack, m1_ack, m0_rd_valid, m1_rd_valid;
  logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
  logic fp_mmio_cs, fp_video_cs, fp_wr, fp_rd;
  logic [ADDR_W-1:0] fp_addr;
  logic [DATA_W-1:0] fp_wr_data, fp_rd_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign fp_rd_data = fp_rd ? slave_word : {DATA_W{1'b1}};

  fpro_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAXB), .INIT_LAST(ILAST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_video(video[0]), .m0_wr(wr[0]), .m0_rd(rd[0]),
    .m0_addr(addr[0]), .m0_wr_data(wdata[0]), .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m0_rd_valid(m0_rd_valid),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_video(video[1]), .m1_wr(wr[1]), .m1_rd(rd[1]),
    .m1_addr(addr[1]), .m1_wr_data(wdata[1]), .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .m1_rd_valid(m1_rd_valid),
    .fp_mmio_cs(fp_mmio_cs), .fp_video_cs(fp_video_cs), .fp_wr(fp_wr), .fp_rd(fp_rd),
    .fp_addr(fp_addr), .fp_wr_data(fp_wr_data), .fp_rd_data(fp_rd_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int owner = -1;      // master currently holding a lock, -1 if none
  int beats = 0;       // consecutive locked beats of that owner
  int last_g = ILAST;
  bit mdl_en = 0;
  logic e_mmio = 0, e_video = 0, e_wr = 0, e_rd = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_wdata = '0;
  logic e_rv [2] = '{0, 0};
  logic [DATA_W-1:0] e_rdata [2] = '{0, 0};
  bit pend = 0;
  int pend_m = 0;
  bit pend_v = 0;

  function automatic int model_grant();
    bit held;
    if (reset) return -1;
    held = (owner >= 0) && lock[owner] && (beats < MAXB);
    if (!req[0] && !req[1]) return -1;
    if (req[0] && req[1]) return held ? owner : 1 - last_g;
    begin
      int solo = req[0] ? 0 : 1;
      if (held && owner != solo) return -1;
      return solo;
    end
  endfunction

  always @(negedge clk) begin
    int g;
    g = model_grant();
    if (mdl_en) begin
      chk("m_ack0", 64'(m0_ack), 64'(g == 0));
      chk("m_ack1", 64'(m1_ack), 64'(g == 1));
      chk("m_fp_ctl", {60'd0, fp_mmio_cs, fp_video_cs, fp_wr, fp_rd},
                      {60'd0, e_mmio, e_video, e_wr, e_rd});
      chk("m_fp_addr", 64'(fp_addr), 64'(e_addr));
      chk("m_fp_wdata", 64'(fp_wr_data), 64'(e_wdata));
      chk("m_rv", {62'd0, m1_rd_valid, m0_rd_valid}, {62'd0, e_rv[1], e_rv[0]});
      chk("m_rdata0", 64'(m0_rd_data), 64'(e_rdata[0]));
      chk("m_rdata1", 64'(m1_rd_data), 64'(e_rdata[1]));
    end
    if (reset) begin
      mdl_en = 1;
      owner = -1; beats = 0; last_g = ILAST; pend = 0;
      {e_mmio, e_video, e_wr, e_rd} = '0;
      e_addr = '0; e_wdata = '0;
      e_rv = '{0, 0}; e_rdata = '{0, 0};
    end else begin
      e_rv = '{0, 0};
      if (pend) begin
        e_rv[pend_m] = 1;
        e_rdata[pend_m] = pend_v ? '0 : slave_word;
      end
      pend = 0;
      {e_mmio, e_video, e_wr, e_rd} = '0;
      e_addr = '0; e_wdata = '0;
      if (g >= 0) begin
        bit w, r;
        w = wr[g];
        r = rd[g] && !wr[g];
        e_wr = w;
        e_rd = r && !video[g];
        e_mmio = !video[g] && (w || r);
        e_video = video[g] && w;
        e_addr = addr[g];
        e_wdata = wdata[g];
        pend = r; pend_m = g; pend_v = video[g];
        if (lock[g]) begin
          beats = (owner == g) ? ((beats + 1 > MAXB) ? MAXB : beats + 1) : 1;
          owner = g;
        end else begin
          owner = -1; beats = 0;
        end
        last_g = g;
      end else begin
        owner = -1; beats = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(input int m, input logic rq, input logic lk, input logic vd,
                         input logic w, input logic r, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req[m] = rq; lock[m] = lk; video[m] = vd; wr[m] = w; rd[m] = r;
    addr[m] = a; wdata[m] = d;
  endtask

  task automatic clr_all();
    req = '0; lock = '0; video = '0; wr = '0; rd = '0;
  endtask

  initial begin
    logic [1:0] seen;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_fp", {58'd0, fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, m0_rd_valid, m1_rd_valid}, 64'd0);

    // round-robin after reset: m1 wins the first tie
    step();
    reset = 0;
    set_cmd(0, 1, 0, 0, 1, 0, 21'h10, 32'h1);
    set_cmd(1, 1, 0, 0, 1, 0, 21'h20, 32'h2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_ack", {62'd0, m1_ack, m0_ack}, (i % 2 == 0) ? 64'd2 : 64'd1);
      step();
    end
    clr_all();

    // single mmio write
    set_cmd(0, 1, 0, 0, 1, 0, 21'h00123, 32'hDEADBEEF);
    @(negedge clk); chk("wr_ack", 64'(m0_ack), 64'd1);
    step(); clr_all();
    @(negedge clk);
    chk("wr_fp", {fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, 7'd0, fp_addr, fp_wr_data},
                 {4'b1010, 7'd0, 21'h00123, 32'hDEADBEEF});
    step();
    @(negedge clk); chk("wr_once", 64'(fp_wr), 64'd0);
    step();

    // m1 mmio read
    slave_word = 32'h0000ABCD;
    set_cmd(1, 1, 0, 0, 0, 1, 21'h00040, 32'h0);
    @(negedge clk); chk("rd_ack", 64'(m1_ack), 64'd1);
    step(); clr_all();
    @(negedge clk); chk("rd_fp", {43'd0, fp_rd, fp_wr, fp_addr}, {43'd0, 2'b10, 21'h00040});
    step();
    @(negedge clk);
    chk("rd_ret", {m1_rd_valid, m0_rd_valid, 30'd0, m1_rd_data}, {2'b10, 30'd0, 32'h0000ABCD});
    step();

    // lock burst, MAX_BURST=4
    set_cmd(0, 1, 1, 0, 1, 0, 21'h111, 32'h5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lock_ack", {62'd0, m1_ack, m0_ack}, (k < 4) ? 64'd1 : 64'd2);
      step();
      set_cmd(1, 1, 0, 0, 1, 0, 21'h222, 32'h6);
    end
    clr_all();
    step();

    // video read by m0
    set_cmd(0, 1, 0, 1, 0, 1, 21'h333, 32'h0);
    @(negedge clk); chk("vrd_ack", 64'(m0_ack), 64'd1);
    step(); clr_all();
    @(negedge clk); chk("vrd_fp", {61'd0, fp_rd, fp_mmio_cs, fp_video_cs}, 64'd0);
    step();
    @(negedge clk); chk("vrd_ret", {31'd0, m0_rd_valid, m0_rd_data}, {31'd0, 1'b1, 32'd0});
    step();

    // wr and rd both high
    set_cmd(1, 1, 0, 0, 1, 1, 21'h444, 32'h77);
    step(); clr_all();
    @(negedge clk); chk("wrrd_fp", {62'd0, fp_wr, fp_rd}, 64'd2);
    step();

    // reset during the fp_rd cycle of an m0 read
    set_cmd(0, 1, 0, 0, 0, 1, 21'h555, 32'h0);
    step(); clr_all(); reset = 1;
    @(negedge clk); chk("rmid_fprd", 64'(fp_rd), 64'd1);
    step(); reset = 0;
    set_cmd(0, 1, 0, 0, 1, 0, 21'h1, 32'h1);
    set_cmd(1, 1, 0, 0, 1, 0, 21'h2, 32'h2);
    @(negedge clk);
    chk("rmid_out", {57'd0, m0_rd_valid, fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, m1_ack, m0_ack},
                    64'd2);
    step(); clr_all();

    // randomized traffic; a master holds its command until acked
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      seen = {m1_ack, m0_ack};
      step();
      reset = ($urandom_range(0, 249) == 0);
      slave_word = $urandom;
      for (int m = 0; m < 2; m++) begin
        lock[m] = ($urandom_range(0, 3) != 0);
        if (!(req[m] && !seen[m])) begin
          req[m] = ($urandom_range(0, 3) != 0);
          video[m] = $urandom_range(0, 1);
          wr[m] = $urandom_range(0, 1);
          rd[m] = $urandom_range(0, 1);
          addr[m] = ADDR_W'($urandom);
          wdata[m] = $urandom;
        end
      end
    end
    clr_all(); reset = 0;
    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
